// File: rtl/apb_pkg.sv
// apb_pkg: shared APB widths and initiator FSM state encoding
package apb_pkg;
  localparam int APB_AW = 12;
  localparam int APB_DW = 32;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_SETUP = 2'd1, ST_ACCESS = 2'd2;
  typedef enum logic [1:0] {IDLE = ST_IDLE, SETUP = ST_SETUP, ACCESS = ST_ACCESS} state_t;
endpackage

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB3/APB4 initiator with wait-state timeout
module apb_master
  import apb_pkg::*;
#(
  parameter int AW = APB_AW,
  parameter int DW = APB_DW,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [DW-1:0]   cmd_wdata,
  input  logic [DW/8-1:0] cmd_strb,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            rsp_timeout,
  output logic            psel,
  output logic            penable,
  output logic            pwrite,
  output logic [AW-1:0]   paddr,
  output logic [DW-1:0]   pwdata,
  output logic [DW/8-1:0] pstrb,
  input  logic            pready,
  input  logic            pslverr,
  input  logic [DW-1:0]   prdata
);
  localparam int TW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);
  state_t state;
  logic [TW-1:0] tcnt;
  logic tmo;
  assign tmo = (TIMEOUT_CYC != 0) && (tcnt == T_LAST);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      tcnt <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      rsp_timeout <= 1'b0;
      psel <= 1'b0;
      penable <= 1'b0;
      pwrite <= 1'b0;
      paddr <= '0;
      pwdata <= '0;
      pstrb <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= !(cmd_valid && cmd_ready);
          if (cmd_valid && cmd_ready) begin
            state <= SETUP;
            tcnt <= '0;
            psel <= 1'b1;
            pwrite <= cmd_write;
            paddr <= cmd_addr;
            pwdata <= cmd_wdata;
            pstrb <= cmd_write ? cmd_strb : '0;
          end
        end
        SETUP: begin
          state <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          if (pready || tmo) begin
            state <= IDLE;
            psel <= 1'b0;
            penable <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_rdata <= (pready && !pwrite) ? prdata : '0;
            rsp_err <= pready ? pslverr : 1'b1;
            rsp_timeout <= !pready;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: table-driven check of apb_master transfers, errors, timeout and reset
module tb_apb_master;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_write = 0;
  logic [11:0] cmd_addr = 0;
  logic [31:0] cmd_wdata = 0;
  logic [3:0] cmd_strb = 0;
  logic cmd_ready, rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0] pstrb;
  logic pready = 0, pslverr = 0;
  logic [31:0] prdata = 0;
  int checks = 0, errors = 0;

  apb_master #(.AW(12), .DW(32), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit write;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0] strb;
    int waits;
    bit slverr;
    logic [31:0] rdata;
    logic [3:0] exp_strb;
    logic [31:0] exp_rdata;
    bit exp_err;
    bit exp_to;
    int exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc, waits, psel_n, pen_n;
    bit stable;
    cyc = 0;
    while (!cmd_ready && cyc < 10) begin tick(); cyc++; end
    chk($sformatf("v%0d_ready", idx), cmd_ready, 1);
    cmd_valid = 1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_strb = v.strb;
    tick();
    cmd_valid = 0; cmd_write = ~v.write; cmd_addr = 12'hABC; cmd_wdata = 32'h0BAD0BAD; cmd_strb = ~v.strb;
    cyc = 1; waits = 0; psel_n = 0; pen_n = 0; stable = 1;
    while (!rsp_valid && cyc < 40) begin
      psel_n += int'(psel);
      pen_n += int'(penable);
      if (psel && {pwrite, paddr, pwdata, pstrb} !== {v.write, v.addr, v.wdata, v.exp_strb}) stable = 0;
      pready = penable && (waits == v.waits);
      pslverr = pready && v.slverr;
      prdata = pready ? v.rdata : 32'hBADC0DE5;
      if (penable && !pready) waits++;
      tick();
      cyc++;
    end
    pready = 0; pslverr = 0; prdata = 0;
    chk($sformatf("v%0d_rsp_seen", idx), rsp_valid, 1);
    chk($sformatf("v%0d_latency", idx), cyc, v.exp_lat);
    chk($sformatf("v%0d_rdata", idx), rsp_rdata, v.exp_rdata);
    chk($sformatf("v%0d_err", idx), rsp_err, v.exp_err);
    chk($sformatf("v%0d_timeout", idx), rsp_timeout, v.exp_to);
    chk($sformatf("v%0d_psel_cycles", idx), psel_n, v.exp_lat - 1);
    chk($sformatf("v%0d_penable_cycles", idx), pen_n, v.exp_lat - 2);
    chk($sformatf("v%0d_bus_stable", idx), stable, 1);
    chk($sformatf("v%0d_done_bus", idx), {psel, penable, cmd_ready}, 3'b001);
    tick();
    chk($sformatf("v%0d_rsp_pulse", idx), rsp_valid, 0);
  endtask

  initial begin
    logic [11:0] addrs[4];
    int acc_cyc[4];
    int k, r, n;
    bit acc, seen;
    vecs[0] = '{1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0, 1'b0, 3};
    vecs[1] = '{1'b0, 12'h010, 32'h11111111, 4'hA, 3, 1'b0, 32'h12345678, 4'h0, 32'h12345678, 1'b0, 1'b0, 6};
    vecs[2] = '{1'b1, 12'hFFC, 32'h00000000, 4'h3, 0, 1'b1, 32'h0, 4'h3, 32'h0, 1'b1, 1'b0, 3};
    vecs[3] = '{1'b0, 12'h020, 32'h0, 4'h0, 99, 1'b0, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b1, 1'b1, 18};
    vecs[4] = '{1'b0, 12'h024, 32'h0, 4'h0, 15, 1'b0, 32'hCAFEF00D, 4'h0, 32'hCAFEF00D, 1'b0, 1'b0, 18};
    vecs[5] = '{1'b1, 12'h008, 32'hA5A5A5A5, 4'h5, 1, 1'b1, 32'h77777777, 4'h5, 32'h0, 1'b1, 1'b0, 4};
    vecs[6] = '{1'b0, 12'h00C, 32'h0, 4'hF, 2, 1'b1, 32'h55AA55AA, 4'h0, 32'h55AA55AA, 1'b1, 1'b0, 5};

    repeat (3) tick();
    chk("reset_outputs", {cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, psel, penable,
                          pwrite, paddr, pwdata, pstrb}, '0);
    rst_n = 1;
    tick();
    chk("ready_after_reset", cmd_ready, 1);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // reset while the slave is inserting wait states
    cmd_valid = 1; cmd_write = 0; cmd_addr = 12'h030;
    tick();
    cmd_valid = 0;
    tick(); tick(); tick();
    chk("mid_rst_in_access", {psel, penable}, 2'b11);
    rst_n = 0;
    tick();
    chk("mid_rst_bus_drop", {psel, penable, rsp_valid}, 3'b000);
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin tick(); seen |= rsp_valid; end
    chk("mid_rst_no_rsp", seen, 0);
    chk("mid_rst_ready", cmd_ready, 1);

    // cmd_valid held high across four zero-wait reads
    addrs = '{12'h100, 12'h104, 12'h108, 12'h10C};
    k = 0; r = 0; n = 0;
    cmd_valid = 1; cmd_write = 0; cmd_addr = addrs[0];
    while ((k < 4 || r < 4) && n < 60) begin
      acc = cmd_valid && cmd_ready;
      if (rsp_valid) begin
        chk($sformatf("b2b_rsp%0d_rdata", r), rsp_rdata, {20'h0, addrs[r & 3]});
        r++;
      end
      pready = penable;
      prdata = {20'h0, paddr};
      tick();
      n++;
      if (acc) begin
        acc_cyc[k] = n;
        k++;
        if (k < 4) cmd_addr = addrs[k];
        else cmd_valid = 0;
      end
    end
    pready = 0;
    chk("b2b_accepts", k, 4);
    chk("b2b_responses", r, 4);
    for (int i = 1; i < 4; i++) chk($sformatf("b2b_spacing%0d", i), acc_cyc[i] - acc_cyc[i-1], 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
